// File: rtl/shift_tx.sv
// UART 8N1 transmitter for an 8-bit LED pattern: sends the pattern whenever it
// changes or when start is requested, one frame at a time.
module shift_tx #(
  parameter int BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       start,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg, state_next;
  logic [7:0]      shreg_reg, shreg_next;
  logic [7:0]      last_reg, last_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_reg, bit_next;
  logic            tx_reg, tx_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            baud_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shreg_reg <= 8'h00;
      last_reg  <= 8'h00;
      cnt_reg   <= '0;
      bit_reg   <= 3'd0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Counter free-runs within a frame and wraps every bit, so bit edges never drift.
  assign baud_end = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    last_next  = last_reg;
    bit_next   = bit_reg;
    tx_next    = tx_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    if (state_reg == IDLE || baud_end) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + CW'(1);
    end

    case (state_reg)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (start || (data != last_reg)) begin
          shreg_next = data;
          last_next  = data;
          state_next = START;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
        end
      end
      START: begin
        if (baud_end) begin
          state_next = DATA;
          tx_next    = shreg_reg[0];
          bit_next   = 3'd0;
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_reg == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            shreg_next = {1'b0, shreg_reg[7:1]};
            bit_next   = bit_reg + 3'd1;
            tx_next    = shreg_reg[1];
          end
        end
      end
      STOP: begin
        // Returning to IDLE here deliberately skips trigger evaluation on this edge.
        if (baud_end) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign tx   = tx_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_shift_tx.sv
// Self-checking bench for shift_tx: a cycle model predicts frame starts into a
// scoreboard, and a line monitor decodes tx and compares each frame slot by slot.
module tb_shift_tx;

  localparam int B = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx, busy, done;

  always #5 clk = ~clk;

  shift_tx #(.BAUD_DIV(B)) dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .start(start),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  typedef struct {
    logic [7:0] b;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int         cyc = 0;
  int         m_rem = 0;
  int         n_push = 0;
  logic [7:0] m_last = 8'h00;
  logic       rst_at_edge = 1'b0;

  // monitor state
  bit         in_frame = 0;
  bit         shift8_mode = 0;
  int         k = 0;
  int         frames_seen = 0;
  logic [7:0] cur_b = 8'h00;
  logic [7:0] rx_b = 8'h00;
  logic [7:0] last_byte = 8'h00;

  // Reference model: decides at each edge whether a frame starts, from inputs only.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      rst_at_edge = rst;
      if (rst) begin
        m_rem  = 0;
        m_last = 8'h00;
      end else if (m_rem > 0) begin
        m_rem = m_rem - 1;
      end else if (start || (data != m_last)) begin
        sb.push_back('{data, cyc});
        m_last = data;
        m_rem  = 10 * B;
        n_push = n_push + 1;
      end
    end
  end

  // Line monitor, sampling on the falling edge.
  initial begin
    exp_t       e;
    int         slot;
    logic       ebit;
    logic [2:0] want;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        in_frame = 0;
        n_vec++;
        if ({tx, busy, done} !== 3'b100) begin
          n_err++;
          $display("FAIL reset_outputs: {tx,busy,done}=%b required 100 at cycle %0d", {tx, busy, done}, cyc);
        end
      end else begin
        if (!in_frame && busy === 1'b1) begin
          in_frame = 1;
          k = 0;
          rx_b = 8'h00;
          n_vec++;
          if (sb.size() == 0) begin
            n_err++;
            cur_b = 8'h00;
            $display("FAIL frame_unexpected: frame began at cycle %0d, required none", cyc);
          end else begin
            e = sb.pop_front();
            cur_b = e.b;
            if (cyc !== e.cyc) begin
              n_err++;
              $display("FAIL frame_start: began at cycle %0d, required cycle %0d", cyc, e.cyc);
            end
          end
        end
        if (in_frame) begin
          slot = k / B;
          if (k == 10 * B) begin
            want = 3'b101;
          end else begin
            ebit = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : cur_b[slot-1];
            want = {ebit, 1'b1, 1'b0};
          end
          n_vec++;
          if ({tx, busy, done} !== want) begin
            n_err++;
            $display("FAIL frame_slot: k=%0d {tx,busy,done}=%b required %b", k, {tx, busy, done}, want);
          end
          if (slot >= 1 && slot <= 8 && (k % B) == B / 2) begin
            rx_b[slot-1] = tx;
          end
          if (k == 10 * B) begin
            n_vec++;
            if (rx_b !== cur_b) begin
              n_err++;
              $display("FAIL frame_byte: decoded %02h required %02h", rx_b, cur_b);
            end
            if (shift8_mode) begin
              n_vec++;
              if ($countones(rx_b) != 1) begin
                n_err++;
                $display("FAIL shift8_onehot: decoded %02h required a single set bit", rx_b);
              end
            end
            $display("frame %0d: decoded %02h expected %02h at cycle %0d", frames_seen, rx_b, cur_b, cyc);
            frames_seen = frames_seen + 1;
            last_byte   = rx_b;
            in_frame    = 0;
          end else begin
            k = k + 1;
          end
        end else begin
          n_vec++;
          if ({tx, busy, done} !== 3'b100) begin
            n_err++;
            $display("FAIL idle_outputs: {tx,busy,done}=%b required 100 at cycle %0d", {tx, busy, done}, cyc);
          end
        end
      end
    end
  end

  task automatic wait_quiet(input int budget);
    int i;
    i = 0;
    while ((m_rem != 0 || in_frame || sb.size() != 0 || data != m_last || start) && i < budget) begin
      @(negedge clk);
      i++;
    end
    n_vec++;
    if (i >= budget) begin
      n_err++;
      $display("FAIL wait_quiet: still active after %0d cycles (queue %0d) required idle", i, sb.size());
    end
    @(negedge clk);
  endtask

  task automatic test_idle();
    int f0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({tx, busy, done} !== 3'b100) begin
      n_err++;
      $display("FAIL idle_in_reset: {tx,busy,done}=%b required 100", {tx, busy, done});
    end
    f0 = frames_seen;
    data = 8'h00;
    rst = 1'b0;
    repeat (100) @(negedge clk);
    n_vec++;
    if (frames_seen !== f0 || sb.size() != 0) begin
      n_err++;
      $display("FAIL idle_no_frame: frames %0d required %0d", frames_seen - f0, 0);
    end
  endtask

  task automatic test_reset();
    int f0;
    @(negedge clk);
    rst = 1'b1;
    data = 8'h01;
    repeat (2) @(negedge clk);
    f0 = frames_seen;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({tx, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_first_edge: {tx,busy}=%b required 01", {tx, busy});
    end
    wait_quiet(200);
    n_vec++;
    if (frames_seen !== f0 + 1 || last_byte !== 8'h01) begin
      n_err++;
      $display("FAIL reset_frame: frames %0d byte %02h required 1 byte 01", frames_seen - f0, last_byte);
    end
  endtask

  task automatic test_mid_change();
    int f0;
    f0 = frames_seen;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    data = 8'h02;
    repeat (12) @(negedge clk);
    data = 8'h04;
    wait_quiet(300);
    n_vec++;
    if (frames_seen !== f0 + 2 || last_byte !== 8'h04) begin
      n_err++;
      $display("FAIL mid_change: frames %0d last %02h required 2 last 04", frames_seen - f0, last_byte);
    end
  endtask

  task automatic test_start();
    int f0;
    f0 = frames_seen;
    @(negedge clk);
    data = 8'hA5;
    wait_quiet(200);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_quiet(200);
    n_vec++;
    if (frames_seen !== f0 + 2 || last_byte !== 8'hA5) begin
      n_err++;
      $display("FAIL start_pulse: frames %0d last %02h required 2 last a5", frames_seen - f0, last_byte);
    end
  endtask

  task automatic test_same_cycle();
    int f0;
    f0 = frames_seen;
    @(negedge clk);
    data = 8'h3C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_quiet(200);
    n_vec++;
    if (frames_seen !== f0 + 1 || last_byte !== 8'h3C) begin
      n_err++;
      $display("FAIL same_cycle: frames %0d last %02h required 1 last 3c", frames_seen - f0, last_byte);
    end
  endtask

  task automatic test_back_to_back();
    int f0;
    f0 = frames_seen;
    @(negedge clk);
    start = 1'b1;
    repeat (2 * (10 * B + 1) + 1) @(negedge clk);
    start = 1'b0;
    wait_quiet(300);
    n_vec++;
    if (frames_seen !== f0 + 3) begin
      n_err++;
      $display("FAIL back_to_back: frames %0d required 3", frames_seen - f0);
    end
  endtask

  task automatic test_reset_mid();
    int f0;
    f0 = frames_seen;
    @(negedge clk);
    data = 8'h33;
    repeat (16) @(negedge clk);
    rst = 1'b1;
    data = 8'h80;
    @(negedge clk);
    n_vec++;
    if ({tx, busy, done} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_mid_abort: {tx,busy,done}=%b required 100", {tx, busy, done});
    end
    rst = 1'b0;
    wait_quiet(200);
    n_vec++;
    if (frames_seen !== f0 + 1 || last_byte !== 8'h80) begin
      n_err++;
      $display("FAIL reset_mid_resend: frames %0d last %02h required 1 last 80", frames_seen - f0, last_byte);
    end
  endtask

  task automatic test_shift8();
    int f0, p0;
    f0 = frames_seen;
    p0 = n_push;
    shift8_mode = 1;
    @(negedge clk);
    data = 8'h01;
    repeat (2000) begin
      @(negedge clk);
      data = {data[6:0], data[7]};
    end
    wait_quiet(200);
    shift8_mode = 0;
    n_vec++;
    if (frames_seen - f0 !== n_push - p0 || frames_seen - f0 < 40) begin
      n_err++;
      $display("FAIL shift8_count: frames %0d required %0d", frames_seen - f0, n_push - p0);
    end
  endtask

  initial begin
    test_idle();
    test_reset();
    test_mid_change();
    test_start();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    test_shift8();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
